// File: rtl/periph_interconnect.sv
// Single-master to NUM_SLV-slave bus with base/mask decode, in-order outstanding FIFO and timeout flush.
// Grant is combinational from the selected slave; responses follow FIFO order, and accepts stall while full or switching slaves.
module periph_interconnect #(
  parameter int NUM_SLV   = 8,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_OUTST = 4,
  parameter int TIMEOUT   = 255,
  parameter int QUIET_CYC = 16,
  parameter logic [NUM_SLV*ADDR_W-1:0] SLV_BASE = '0,
  parameter logic [NUM_SLV*ADDR_W-1:0] SLV_MASK = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      m_req,
  input  logic                      m_we,
  input  logic [DATA_W/8-1:0]       m_be,
  input  logic [ADDR_W-1:0]         m_addr,
  input  logic [DATA_W-1:0]         m_wdata,
  output logic                      m_gnt,
  output logic                      m_rvalid,
  output logic [DATA_W-1:0]         m_rdata,
  output logic                      m_err,
  output logic [NUM_SLV-1:0]        s_req,
  output logic                      s_we,
  output logic [DATA_W/8-1:0]       s_be,
  output logic [ADDR_W-1:0]         s_addr,
  output logic [DATA_W-1:0]         s_wdata,
  input  logic [NUM_SLV-1:0]        s_gnt,
  input  logic [NUM_SLV-1:0]        s_rvalid,
  input  logic [NUM_SLV*DATA_W-1:0] s_rdata,
  input  logic [NUM_SLV-1:0]        s_err,
  output logic                      tmo_pulse,
  output logic [3:0]                tmo_slv
);

  localparam int PTR_W  = $clog2(MAX_OUTST);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WCNT_W = $clog2(TIMEOUT + 1) + 1;
  localparam int QCNT_W = $clog2(QUIET_CYC + 1) + 1;

  typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_QUIET} state_e;
  typedef struct packed {
    logic [3:0] idx;
    logic       decerr;
  } ent_t;

  state_e             state_q, state_d;
  ent_t               fifo_q [MAX_OUTST];
  ent_t               tail_q, tail_d, head, push_ent;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
  logic [QCNT_W-1:0]  qcnt_q, qcnt_d;
  logic               tmo_pulse_q, tmo_pulse_d;
  logic [3:0]         tmo_slv_q, tmo_slv_d;
  logic               hit_any;
  logic [3:0]         hit_idx;
  logic               empty, full, ok, push, pop;
  logic               h_rvalid, h_err;
  logic [DATA_W-1:0]  h_rdata;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CNT_W'(MAX_OUTST));
  assign head  = fifo_q[rd_ptr_q];

  // Descending scan so the lowest matching index wins on overlapping windows.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int i = NUM_SLV - 1; i >= 0; i--) begin
      if ((m_addr & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]) begin
        hit_any = 1'b1;
        hit_idx = 4'(i);
      end
    end
  end

  always_comb begin
    h_rvalid = 1'b0;
    h_rdata  = '0;
    h_err    = 1'b0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (head.idx == 4'(i)) begin
        h_rvalid = s_rvalid[i];
        h_rdata  = s_rdata[i*DATA_W +: DATA_W];
        h_err    = s_err[i];
      end
    end
  end

  // Only new requests to the slave already at the tail may overtake nothing, keeping responses in order.
  assign ok = rst && (state_q == ST_RUN) && !full &&
              (empty || (hit_idx == tail_q.idx)) && !(!empty && tail_q.decerr);

  assign s_we      = rst & m_we;
  assign s_be      = rst ? m_be : '0;
  assign s_addr    = rst ? m_addr : '0;
  assign s_wdata   = rst ? m_wdata : '0;
  assign tmo_pulse = tmo_pulse_q;
  assign tmo_slv   = tmo_slv_q;

  always_comb begin
    for (int i = 0; i < NUM_SLV; i++) begin
      s_req[i] = m_req && ok && hit_any && (hit_idx == 4'(i));
    end
    m_gnt           = hit_any ? |(s_req & s_gnt) : (m_req && ok);
    push            = m_gnt;
    push_ent.idx    = hit_idx;
    push_ent.decerr = !hit_any;

    m_rvalid = 1'b0;
    m_rdata  = '0;
    m_err    = 1'b0;
    if (!empty) begin
      if (state_q == ST_FLUSH) begin
        m_rvalid = 1'b1;
        m_err    = 1'b1;
        m_rdata  = DATA_W'(32'hDEAD_BEEF);
      end else if (state_q == ST_RUN) begin
        if (head.decerr) begin
          m_rvalid = 1'b1;
          m_err    = 1'b1;
        end else if (h_rvalid) begin
          m_rvalid = 1'b1;
          m_rdata  = h_rdata;
          m_err    = h_err;
        end
      end
    end
    pop = m_rvalid;

    cnt_d       = cnt_q + CNT_W'(push) - CNT_W'(pop);
    wr_ptr_d    = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d    = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    tail_d      = push ? push_ent : tail_q;
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    qcnt_d      = qcnt_q;
    tmo_pulse_d = 1'b0;
    tmo_slv_d   = tmo_slv_q;

    case (state_q)
      ST_RUN: begin
        if (empty || pop) begin
          wcnt_d = '0;
        end else if (wcnt_q == WCNT_W'(TIMEOUT)) begin
          state_d     = ST_FLUSH;
          tmo_pulse_d = 1'b1;
          tmo_slv_d   = head.idx;
          wcnt_d      = '0;
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end
      ST_FLUSH: begin
        if (cnt_d == '0) begin
          state_d = ST_QUIET;
          qcnt_d  = '0;
        end
      end
      default: begin
        // Late responses from the flushed slave land here and are simply not forwarded.
        if (qcnt_q == QCNT_W'(QUIET_CYC - 1)) begin
          state_d = ST_RUN;
          qcnt_d  = '0;
        end else begin
          qcnt_d = qcnt_q + QCNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_RUN;
      tail_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      wcnt_q      <= '0;
      qcnt_q      <= '0;
      tmo_pulse_q <= 1'b0;
      tmo_slv_q   <= '0;
      for (int i = 0; i < MAX_OUTST; i++) fifo_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      tail_q      <= tail_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      wcnt_q      <= wcnt_d;
      qcnt_q      <= qcnt_d;
      tmo_pulse_q <= tmo_pulse_d;
      tmo_slv_q   <= tmo_slv_d;
      if (push) fifo_q[wr_ptr_q] <= push_ent;
    end
  end

endmodule

// File: tb/tb_periph_interconnect.sv
// Scoreboard bench for periph_interconnect: expected responses are queued at issue and matched as m_rvalid appears.
module tb_periph_interconnect;
  localparam int NUM_SLV = 8, ADDR_W = 32, DATA_W = 32, MAX_OUTST = 4, TIMEOUT = 255, QUIET_CYC = 16;
  localparam logic [NUM_SLV*ADDR_W-1:0] BASES = {32'h1000_7000, 32'h1000_6000, 32'h1000_5000, 32'h1000_4000,
                                                 32'h1000_3000, 32'h1000_2000, 32'h1000_1000, 32'h1000_0000};
  localparam logic [NUM_SLV*ADDR_W-1:0] MASKS = {NUM_SLV{32'hFFFF_F000}};

  logic clk = 1'b0, rst = 1'b0;
  logic m_req, m_we;
  logic [DATA_W/8-1:0] m_be;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic m_gnt, m_rvalid, m_err;
  logic [DATA_W-1:0] m_rdata;
  logic [NUM_SLV-1:0] s_req, s_gnt, s_rvalid, s_err;
  logic s_we;
  logic [DATA_W/8-1:0] s_be;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_wdata;
  logic [NUM_SLV*DATA_W-1:0] s_rdata;
  logic tmo_pulse;
  logic [3:0] tmo_slv;

  typedef struct {
    logic [DATA_W-1:0] d;
    logic              e;
  } exp_t;
  exp_t sb[$];
  int checks = 0, passes = 0;

  periph_interconnect #(
    .NUM_SLV(NUM_SLV), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUTST(MAX_OUTST),
    .TIMEOUT(TIMEOUT), .QUIET_CYC(QUIET_CYC), .SLV_BASE(BASES), .SLV_MASK(MASKS)
  ) dut (
    .clk(clk), .rst(rst), .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_err(m_err),
    .s_req(s_req), .s_we(s_we), .s_be(s_be), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_err(s_err),
    .tmo_pulse(tmo_pulse), .tmo_slv(tmo_slv)
  );

  always #5 clk = ~clk;

  // Response monitor: every m_rvalid must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst && m_rvalid) begin
      checks++;
      if (sb.size() == 0) begin
        $display("FAIL mon_unexpected: rvalid with rdata=%h err=%b, none expected", m_rdata, m_err);
      end else begin
        e = sb.pop_front();
        if (m_rdata !== e.d || m_err !== e.e)
          $display("FAIL mon_resp: got rdata=%h err=%b, want rdata=%h err=%b", m_rdata, m_err, e.d, e.e);
        else passes++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m_req = 1'b0; m_we = 1'b0; m_be = '0; m_addr = '0; m_wdata = '0;
    s_gnt = '0; s_rvalid = '0; s_err = '0; s_rdata = '0;
  endtask

  task automatic test_reset();
    idle();
    m_req = 1'b1; m_addr = 32'h1000_0000; m_wdata = 32'hFFFF_FFFF; s_gnt = '1; s_rvalid = '1;
    @(negedge clk);
    checks++; if (m_gnt !== 1'b0) $display("FAIL rst_gnt: got %b want 0", m_gnt); else passes++;
    checks++; if (s_req !== 8'h00) $display("FAIL rst_sreq: got %h want 00", s_req); else passes++;
    checks++; if (m_rvalid !== 1'b0) $display("FAIL rst_rvalid: got %b want 0", m_rvalid); else passes++;
    checks++; if (m_rdata !== 32'h0) $display("FAIL rst_rdata: got %h want 0", m_rdata); else passes++;
    checks++; if (m_err !== 1'b0) $display("FAIL rst_err: got %b want 0", m_err); else passes++;
    checks++; if (s_addr !== 32'h0 || s_wdata !== 32'h0) $display("FAIL rst_bcast: got %h/%h want 0/0", s_addr, s_wdata); else passes++;
    checks++; if (tmo_pulse !== 1'b0 || tmo_slv !== 4'd0) $display("FAIL rst_tmo: got %b/%0d want 0/0", tmo_pulse, tmo_slv); else passes++;
    cyc(); idle();
    cyc(); rst = 1'b1;
  endtask

  task automatic test_single_read();
    cyc(); m_req = 1'b1; m_addr = 32'h1000_0010; s_gnt = 8'h01;
    @(negedge clk);
    checks++; if (s_req !== 8'h01) $display("FAIL t1_sreq: got %h want 01", s_req); else passes++;
    checks++; if (m_gnt !== 1'b1) $display("FAIL t1_gnt: got %b want 1", m_gnt); else passes++;
    sb.push_back('{32'h0000_1234, 1'b0});
    cyc(); m_req = 1'b0; s_gnt = '0;
    @(negedge clk);
    checks++; if (m_rvalid !== 1'b0) $display("FAIL t1_early: got rvalid %b want 0", m_rvalid); else passes++;
    cyc(); s_rvalid = 8'h01; s_rdata[0 +: DATA_W] = 32'h0000_1234;
    @(negedge clk);
    checks++; if (m_rvalid !== 1'b1) $display("FAIL t1_rvalid: got %b want 1", m_rvalid); else passes++;
    cyc(); idle();
  endtask

  task automatic test_decerr();
    cyc(); m_req = 1'b1; m_addr = 32'h9000_0000;
    @(negedge clk);
    checks++; if (m_gnt !== 1'b1) $display("FAIL t2_gnt: got %b want 1", m_gnt); else passes++;
    checks++; if (s_req !== 8'h00) $display("FAIL t2_sreq: got %h want 00", s_req); else passes++;
    sb.push_back('{32'h0, 1'b1});
    cyc(); m_req = 1'b0;
    @(negedge clk);
    checks++; if (m_rvalid !== 1'b1) $display("FAIL t2_rvalid: got %b want 1", m_rvalid); else passes++;
    cyc();
    @(negedge clk);
    checks++; if (m_rvalid !== 1'b0) $display("FAIL t2_after: got rvalid %b want 0", m_rvalid); else passes++;
  endtask

  task automatic test_back_to_back();
    logic exp_gnt;
    int pushed = 0;
    cyc(); m_req = 1'b1; m_addr = 32'h1000_1004; s_gnt = 8'h02;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) cyc();
      s_rvalid = (c == 6) ? 8'h02 : 8'h00;
      s_rdata[DATA_W +: DATA_W] = 32'hA000_0000;
      @(negedge clk);
      // Four fill the FIFO; the pop in cycle 6 frees a slot only for cycle 7.
      exp_gnt = (c < 4) || (c == 7);
      checks++; if (m_gnt !== exp_gnt) $display("FAIL t3_gnt c%0d: got %b want %b", c, m_gnt, exp_gnt); else passes++;
      if (exp_gnt) begin
        sb.push_back('{32'hA000_0000 + 32'(pushed), 1'b0});
        pushed++;
      end
    end
    for (int k = 1; k < 5; k++) begin
      cyc(); m_req = 1'b0; s_gnt = '0; s_rvalid = 8'h02; s_rdata[DATA_W +: DATA_W] = 32'hA000_0000 + 32'(k);
      @(negedge clk);
      checks++; if (m_rvalid !== 1'b1) $display("FAIL t3_drain k%0d: got %b want 1", k, m_rvalid); else passes++;
    end
    cyc(); idle();
  endtask

  task automatic test_slave_switch();
    cyc(); m_req = 1'b1; m_addr = 32'h1000_1000; s_gnt = 8'h02;
    @(negedge clk);
    checks++; if (m_gnt !== 1'b1) $display("FAIL t4_gnt1: got %b want 1", m_gnt); else passes++;
    sb.push_back('{32'hB000_0001, 1'b0});
    cyc(); m_addr = 32'h1000_2000; s_gnt = 8'h04; s_rvalid = 8'h04; s_rdata[2*DATA_W +: DATA_W] = 32'hBAD0_BAD0;
    @(negedge clk);
    checks++; if (m_gnt !== 1'b0 || s_req !== 8'h00) $display("FAIL t4_stall: got gnt=%b sreq=%h want 0/00", m_gnt, s_req); else passes++;
    checks++; if (m_rvalid !== 1'b0) $display("FAIL t4_nonhead: got rvalid %b want 0", m_rvalid); else passes++;
    cyc(); s_rvalid = 8'h02; s_rdata[DATA_W +: DATA_W] = 32'hB000_0001;
    @(negedge clk);
    checks++; if (m_gnt !== 1'b0) $display("FAIL t4_stall2: got gnt %b want 0", m_gnt); else passes++;
    cyc(); s_rvalid = '0;
    @(negedge clk);
    checks++; if (m_gnt !== 1'b1 || s_req !== 8'h04) $display("FAIL t4_gnt2: got gnt=%b sreq=%h want 1/04", m_gnt, s_req); else passes++;
    sb.push_back('{32'hB000_0002, 1'b0});
    cyc(); m_req = 1'b0; s_gnt = '0; s_rvalid = 8'h04; s_rdata[2*DATA_W +: DATA_W] = 32'hB000_0002;
    @(negedge clk);
    checks++; if (m_rvalid !== 1'b1) $display("FAIL t4_rvalid2: got %b want 1", m_rvalid); else passes++;
    cyc(); idle();
  endtask

  task automatic test_timeout();
    int n;
    cyc(); m_req = 1'b1; m_addr = 32'h1000_3000; s_gnt = 8'h08;
    @(negedge clk);
    checks++; if (m_gnt !== 1'b1) $display("FAIL t5_gnt0: got %b want 1", m_gnt); else passes++;
    sb.push_back('{32'hDEAD_BEEF, 1'b1});
    cyc();
    @(negedge clk);
    checks++; if (m_gnt !== 1'b1) $display("FAIL t5_gnt1: got %b want 1", m_gnt); else passes++;
    sb.push_back('{32'hDEAD_BEEF, 1'b1});
    cyc(); m_req = 1'b0; s_gnt = '0;
    @(negedge clk);
    n = 2;
    while (!tmo_pulse && n < TIMEOUT + 20) begin
      cyc();
      @(negedge clk);
      n++;
    end
    // wcnt holds k-1 in cycle k after the first grant; it equals TIMEOUT in cycle TIMEOUT+1 and fires on that edge.
    checks++; if (n !== TIMEOUT + 2) $display("FAIL t5_fire_cycle: got %0d want %0d", n, TIMEOUT + 2); else passes++;
    checks++; if (tmo_slv !== 4'd3) $display("FAIL t5_slv: got %0d want 3", tmo_slv); else passes++;
    checks++; if (m_rvalid !== 1'b1) $display("FAIL t5_flush0: got rvalid %b want 1", m_rvalid); else passes++;
    cyc();
    @(negedge clk);
    checks++; if (tmo_pulse !== 1'b0 || tmo_slv !== 4'd3) $display("FAIL t5_pulse_len: got %b/%0d want 0/3", tmo_pulse, tmo_slv); else passes++;
    checks++; if (m_rvalid !== 1'b1) $display("FAIL t5_flush1: got rvalid %b want 1", m_rvalid); else passes++;
    for (int q = 0; q < QUIET_CYC; q++) begin
      cyc(); m_req = 1'b1; m_addr = 32'h1000_0020; s_gnt = 8'h01;
      s_rvalid = 8'h08; s_rdata[3*DATA_W +: DATA_W] = 32'h5555_5555;
      @(negedge clk);
      checks++; if (m_gnt !== 1'b0 || s_req !== 8'h00) $display("FAIL t5_quiet_gnt q%0d: got %b/%h want 0/00", q, m_gnt, s_req); else passes++;
      checks++; if (m_rvalid !== 1'b0) $display("FAIL t5_quiet_rv q%0d: got %b want 0", q, m_rvalid); else passes++;
    end
    cyc(); s_rvalid = '0;
    @(negedge clk);
    checks++; if (m_gnt !== 1'b1) $display("FAIL t5_resume: got gnt %b want 1", m_gnt); else passes++;
    sb.push_back('{32'h0000_C0DE, 1'b0});
    cyc(); m_req = 1'b0; s_gnt = '0; s_rvalid = 8'h01; s_rdata[0 +: DATA_W] = 32'h0000_C0DE;
    @(negedge clk);
    checks++; if (m_rvalid !== 1'b1) $display("FAIL t5_resume_rv: got %b want 1", m_rvalid); else passes++;
    cyc(); idle();
  endtask

  task automatic test_reset_mid();
    cyc(); m_req = 1'b1; m_addr = 32'h1000_5000; m_wdata = 32'h1111_2222; s_gnt = 8'h20;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) cyc();
      @(negedge clk);
      checks++; if (m_gnt !== 1'b1) $display("FAIL t6_gnt c%0d: got %b want 1", c, m_gnt); else passes++;
      sb.push_back('{32'h0, 1'b0});
    end
    cyc(); s_rvalid = 8'h20;
    #2 rst = 1'b0;
    #1;
    checks++; if (m_gnt !== 1'b0 || s_req !== 8'h00) $display("FAIL t6_async_gnt: got %b/%h want 0/00", m_gnt, s_req); else passes++;
    checks++; if (m_rvalid !== 1'b0 || m_rdata !== 32'h0) $display("FAIL t6_async_rv: got %b/%h want 0/0", m_rvalid, m_rdata); else passes++;
    checks++; if (s_addr !== 32'h0 || s_wdata !== 32'h0) $display("FAIL t6_async_bcast: got %h/%h want 0/0", s_addr, s_wdata); else passes++;
    sb.delete();
    cyc(); idle();
    cyc(); rst = 1'b1;
    cyc(); m_req = 1'b1; m_addr = 32'h1000_6000; s_gnt = 8'h40;
    @(negedge clk);
    checks++; if (m_gnt !== 1'b1 || s_req !== 8'h40) $display("FAIL t6_resume: got %b/%h want 1/40", m_gnt, s_req); else passes++;
    sb.push_back('{32'h0000_6666, 1'b0});
    cyc(); m_req = 1'b0; s_gnt = '0; s_rvalid = 8'h40; s_rdata[6*DATA_W +: DATA_W] = 32'h0000_6666;
    @(negedge clk);
    checks++; if (m_rvalid !== 1'b1) $display("FAIL t6_rvalid: got %b want 1", m_rvalid); else passes++;
    cyc(); idle();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_decerr();
    test_back_to_back();
    test_slave_switch();
    test_timeout();
    test_reset_mid();
    cyc();
    checks++; if (sb.size() !== 0) $display("FAIL sb_empty: got %0d pending want 0", sb.size()); else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
